// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch stage controller with IF/ID register.
// Generates the fetch pc and instruction-memory requests, and resolves redirects
// with priority flush > stall > branch > sequential. An illegal target (a
// misaligned address, one past the end of the memory, or a wrap past the top
// of the 32-bit space) parks the block in a sticky fault state.
// Ports:
//   clk, rst (async, active-low)        clock and reset
//   stall, flush, new_pc                pipeline hold and redirect requests
//   branch_flag, branch_target_addr     taken branch/jump resolved in ID
//   rom_inst                            instruction word from memory (combinational)
//   rom_ce, rom_addr                    memory enable and word index (pc >> 2)
//   pc                                  current fetch byte address
//   id_pc, id_inst, id_valid            IF/ID pipeline register
//   fault, fault_pc                     sticky fault flag and offending address
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned INST_MEM_NUM = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target_addr,
   input  logic [31:0] rom_inst,
   output logic        rom_ce,
   output logic [31:0] rom_addr,
   output logic [31:0] pc,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        fault,
   output logic [31:0] fault_pc
);

   typedef enum logic [1:0] {BOOT, RUN, HOLD, FAULT} state_t;

   state_t      state;
   logic [32:0] seq_sum;
   logic [31:0] cand;
   logic        cand_bad;
   logic        flush_bad;

   function automatic logic illegal(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= INST_MEM_NUM);
   endfunction

   // Carry out of pc+4 flags a wrap, which would otherwise look like address 0.
   always_comb begin
      seq_sum  = {1'b0, pc} + 33'd4;
      cand     = seq_sum[31:0];
      cand_bad = seq_sum[32] || illegal(seq_sum[31:0]);
      if (branch_flag) begin
         cand     = branch_target_addr;
         cand_bad = illegal(branch_target_addr);
      end
      flush_bad = illegal(new_pc);
   end

   assign rom_addr = {2'b00, pc[31:2]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         rom_ce   <= 1'b0;
         id_pc    <= '0;
         id_inst  <= '0;
         id_valid <= 1'b0;
         fault    <= 1'b0;
         fault_pc <= '0;
      end else begin
         case (state)
            BOOT: begin
               state  <= RUN;
               rom_ce <= 1'b1;
            end
            RUN, HOLD: begin
               if (flush || (!stall && cand_bad)) begin
                  // Both a redirect and a fault empty IF/ID.
                  id_pc    <= '0;
                  id_inst  <= '0;
                  id_valid <= 1'b0;
                  if (flush && !flush_bad) begin
                     pc     <= new_pc;
                     state  <= RUN;
                     rom_ce <= 1'b1;
                  end else begin
                     fault    <= 1'b1;
                     fault_pc <= flush ? new_pc : cand;
                     state    <= FAULT;
                     rom_ce   <= 1'b0;
                  end
               end else if (stall) begin
                  state <= HOLD;
               end else begin
                  // The word in IF is always kept, including a branch delay slot.
                  id_pc    <= pc;
                  id_inst  <= rom_inst;
                  id_valid <= 1'b1;
                  pc       <= cand;
                  state    <= RUN;
               end
            end
            FAULT: begin
               if (flush) begin
                  if (flush_bad) begin
                     fault_pc <= new_pc;
                  end else begin
                     pc     <= new_pc;
                     fault  <= 1'b0;
                     rom_ce <= 1'b1;
                     state  <= RUN;
                  end
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Testbench for inst_fetch_ctrl: a table of per-cycle vectors is driven through
// a scoreboard queue on the default-size instance, then hand-written sequences
// cover reset during a stall and sequential overrun on a 4-word memory.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, rst4;
   logic        stall, flush, branch_flag;
   logic [31:0] new_pc, branch_target_addr;

   logic        rom_ce, id_valid, fault;
   logic [31:0] rom_inst, rom_addr, pc, id_pc, id_inst, fault_pc;
   logic        rom_ce4, id_valid4, fault4;
   logic [31:0] rom_inst4, rom_addr4, pc4, id_pc4, id_inst4, fault_pc4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Memory model: word at index n holds 0x1000_0000 + n.
   assign rom_inst  = 32'h1000_0000 + rom_addr;
   assign rom_inst4 = 32'h1000_0000 + rom_addr4;

   inst_fetch_ctrl dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
      .branch_flag(branch_flag), .branch_target_addr(branch_target_addr),
      .rom_inst(rom_inst), .rom_ce(rom_ce), .rom_addr(rom_addr), .pc(pc),
      .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
      .fault(fault), .fault_pc(fault_pc)
   );

   inst_fetch_ctrl #(.INST_MEM_NUM(4)) dut4 (
      .clk(clk), .rst(rst4), .stall(stall), .flush(flush), .new_pc(new_pc),
      .branch_flag(branch_flag), .branch_target_addr(branch_target_addr),
      .rom_inst(rom_inst4), .rom_ce(rom_ce4), .rom_addr(rom_addr4), .pc(pc4),
      .id_pc(id_pc4), .id_inst(id_inst4), .id_valid(id_valid4),
      .fault(fault4), .fault_pc(fault_pc4)
   );

   typedef struct {
      logic        stall, flush;
      logic [31:0] new_pc;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic        ce, val;
      logic [31:0] ipc, iinst;
      logic        flt;
      logic [31:0] fpc;
   } vec_t;

   vec_t tbl[27];
   vec_t exp_q[$];

   function automatic logic [31:0] inst_at(input logic [31:0] p);
      return 32'h1000_0000 + (p >> 2);
   endfunction

   function automatic vec_t mk(input logic s, f, input logic [31:0] np,
                               input logic b, input logic [31:0] t, epc,
                               input logic ce, val, input logic [31:0] ipc,
                               input logic flt, input logic [31:0] fpc);
      vec_t v;
      v.stall = s;  v.flush = f;  v.new_pc = np;  v.br = b;  v.tgt = t;
      v.pc = epc;   v.ce = ce;    v.val = val;    v.ipc = ipc;
      v.iinst = val ? inst_at(ipc) : 32'h0;
      v.flt = flt;  v.fpc = fpc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset4(input string tag);
      chk({tag, " pc"}, pc4, 32'h0);
      chk({tag, " rom_addr"}, rom_addr4, 32'h0);
      chk({tag, " rom_ce"}, {31'b0, rom_ce4}, 32'h0);
      chk({tag, " id_pc"}, id_pc4, 32'h0);
      chk({tag, " id_inst"}, id_inst4, 32'h0);
      chk({tag, " id_valid"}, {31'b0, id_valid4}, 32'h0);
      chk({tag, " fault"}, {31'b0, fault4}, 32'h0);
      chk({tag, " fault_pc"}, fault_pc4, 32'h0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " pc"}, pc, 32'h0);
      chk({tag, " rom_addr"}, rom_addr, 32'h0);
      chk({tag, " rom_ce"}, {31'b0, rom_ce}, 32'h0);
      chk({tag, " id_pc"}, id_pc, 32'h0);
      chk({tag, " id_inst"}, id_inst, 32'h0);
      chk({tag, " id_valid"}, {31'b0, id_valid}, 32'h0);
      chk({tag, " fault"}, {31'b0, fault}, 32'h0);
      chk({tag, " fault_pc"}, fault_pc, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vec_t e;
      //           s  f  new_pc      br tgt        pc        ce val id_pc     flt fault_pc
      tbl[0]  = mk(0, 0, 32'h0,      0, 32'h0,     32'h0,    1, 0, 32'h0,    0, 32'h0);
      tbl[1]  = mk(0, 0, 32'h0,      0, 32'h0,     32'h4,    1, 1, 32'h0,    0, 32'h0);
      tbl[2]  = mk(0, 0, 32'h0,      0, 32'h0,     32'h8,    1, 1, 32'h4,    0, 32'h0);
      tbl[3]  = mk(0, 0, 32'h0,      1, 32'h40,    32'h40,   1, 1, 32'h8,    0, 32'h0);
      tbl[4]  = mk(0, 0, 32'h0,      0, 32'h0,     32'h44,   1, 1, 32'h40,   0, 32'h0);
      tbl[5]  = mk(0, 1, 32'hC,      0, 32'h0,     32'hC,    1, 0, 32'h0,    0, 32'h0);
      tbl[6]  = mk(0, 0, 32'h0,      0, 32'h0,     32'h10,   1, 1, 32'hC,    0, 32'h0);
      tbl[7]  = mk(1, 0, 32'h0,      0, 32'h0,     32'h10,   1, 1, 32'hC,    0, 32'h0);
      tbl[8]  = mk(1, 0, 32'h0,      0, 32'h0,     32'h10,   1, 1, 32'hC,    0, 32'h0);
      tbl[9]  = mk(1, 0, 32'h0,      1, 32'h200,   32'h10,   1, 1, 32'hC,    0, 32'h0);
      tbl[10] = mk(0, 0, 32'h0,      0, 32'h0,     32'h14,   1, 1, 32'h10,   0, 32'h0);
      tbl[11] = mk(0, 0, 32'h0,      0, 32'h0,     32'h18,   1, 1, 32'h14,   0, 32'h0);
      tbl[12] = mk(1, 1, 32'h80,     1, 32'h40,    32'h80,   1, 0, 32'h0,    0, 32'h0);
      tbl[13] = mk(0, 0, 32'h0,      0, 32'h0,     32'h84,   1, 1, 32'h80,   0, 32'h0);
      tbl[14] = mk(0, 0, 32'h0,      1, 32'h42,    32'h84,   0, 0, 32'h0,    1, 32'h42);
      tbl[15] = mk(0, 0, 32'h0,      0, 32'h0,     32'h84,   0, 0, 32'h0,    1, 32'h42);
      tbl[16] = mk(0, 1, 32'h3,      0, 32'h0,     32'h84,   0, 0, 32'h0,    1, 32'h3);
      tbl[17] = mk(0, 1, 32'h100,    0, 32'h0,     32'h100,  1, 0, 32'h0,    0, 32'h3);
      tbl[18] = mk(0, 0, 32'h0,      0, 32'h0,     32'h104,  1, 1, 32'h100,  0, 32'h3);
      tbl[19] = mk(0, 1, 32'h1000,   0, 32'h0,     32'h104,  0, 0, 32'h0,    1, 32'h1000);
      tbl[20] = mk(0, 1, 32'hFFC,    0, 32'h0,     32'hFFC,  1, 0, 32'h0,    0, 32'h1000);
      tbl[21] = mk(0, 0, 32'h0,      0, 32'h0,     32'hFFC,  0, 0, 32'h0,    1, 32'h1000);
      tbl[22] = mk(0, 1, 32'hFF8,    0, 32'h0,     32'hFF8,  1, 0, 32'h0,    0, 32'h1000);
      tbl[23] = mk(0, 0, 32'h0,      0, 32'h0,     32'hFFC,  1, 1, 32'hFF8,  0, 32'h1000);
      tbl[24] = mk(1, 0, 32'h0,      0, 32'h0,     32'hFFC,  1, 1, 32'hFF8,  0, 32'h1000);
      tbl[25] = mk(1, 1, 32'h20,     0, 32'h0,     32'h20,   1, 0, 32'h0,    0, 32'h1000);
      tbl[26] = mk(0, 0, 32'h0,      0, 32'h0,     32'h24,   1, 1, 32'h20,   0, 32'h1000);

      rst = 1'b0;  rst4 = 1'b0;
      stall = 1'b0;  flush = 1'b0;  branch_flag = 1'b0;
      new_pc = '0;  branch_target_addr = '0;
      #2;
      chk_reset("reset");

      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 27; i++) begin
         stall = tbl[i].stall;  flush = tbl[i].flush;  new_pc = tbl[i].new_pc;
         branch_flag = tbl[i].br;  branch_target_addr = tbl[i].tgt;
         exp_q.push_back(tbl[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk($sformatf("r%0d pc", i), pc, e.pc);
         chk($sformatf("r%0d rom_addr", i), rom_addr, e.pc >> 2);
         chk($sformatf("r%0d rom_ce", i), {31'b0, rom_ce}, {31'b0, e.ce});
         chk($sformatf("r%0d id_valid", i), {31'b0, id_valid}, {31'b0, e.val});
         chk($sformatf("r%0d id_pc", i), id_pc, e.ipc);
         chk($sformatf("r%0d id_inst", i), id_inst, e.iinst);
         chk($sformatf("r%0d fault", i), {31'b0, fault}, {31'b0, e.flt});
         chk($sformatf("r%0d fault_pc", i), fault_pc, e.fpc);
         @(negedge clk);
      end
      stall = 1'b0;  flush = 1'b0;  branch_flag = 1'b0;

      // Reset asserted in the middle of a stall, between clock edges.
      stall = 1'b1;
      @(posedge clk);
      #1;
      chk("stall hold pc", pc, 32'h24);
      chk("stall hold id_pc", id_pc, 32'h20);
      #2;
      rst = 1'b0;
      #1;
      chk_reset("async reset mid-stall");
      @(negedge clk);
      stall = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset edge1 rom_ce", {31'b0, rom_ce}, 32'h1);
      chk("post-reset edge1 id_valid", {31'b0, id_valid}, 32'h0);
      chk("post-reset edge1 pc", pc, 32'h0);
      @(posedge clk);
      #1;
      chk("post-reset edge2 id_valid", {31'b0, id_valid}, 32'h1);
      chk("post-reset edge2 id_pc", id_pc, 32'h0);
      chk("post-reset edge2 id_inst", id_inst, 32'h1000_0000);
      chk("post-reset edge2 pc", pc, 32'h4);

      // Four-word memory: sequential fetch runs off the end.
      chk_reset4("mem4 reset");
      @(negedge clk);
      rst4 = 1'b1;
      @(posedge clk);
      #1;
      chk("mem4 boot rom_ce", {31'b0, rom_ce4}, 32'h1);
      chk("mem4 boot pc", pc4, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("mem4 k%0d id_pc", k), id_pc4, 32'(4 * k));
         chk($sformatf("mem4 k%0d id_inst", k), id_inst4, 32'h1000_0000 + 32'(k));
         chk($sformatf("mem4 k%0d id_valid", k), {31'b0, id_valid4}, 32'h1);
         chk($sformatf("mem4 k%0d pc", k), pc4, 32'(4 * k + 4));
      end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("mem4 fault%0d fault", k), {31'b0, fault4}, 32'h1);
         chk($sformatf("mem4 fault%0d fault_pc", k), fault_pc4, 32'h10);
         chk($sformatf("mem4 fault%0d pc", k), pc4, 32'hC);
         chk($sformatf("mem4 fault%0d rom_ce", k), {31'b0, rom_ce4}, 32'h0);
         chk($sformatf("mem4 fault%0d id_valid", k), {31'b0, id_valid4}, 32'h0);
         chk($sformatf("mem4 fault%0d id_pc", k), id_pc4, 32'h0);
      end
      #2;
      rst4 = 1'b0;
      #1;
      chk_reset4("mem4 reset in fault");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
